// File: rtl/byte_swap_arbiter.sv
// Two-requester round-robin arbiter that feeds a shared byte-order swap datapath
// into one registered output stage. The output stage has valid/ready flow control.
module byte_swap_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req0_valid_i,
  input  logic [DATA_WIDTH-1:0] req0_data_i,
  input  logic                  req0_swap_i,
  output logic                  req0_ready_o,
  input  logic                  req1_valid_i,
  input  logic [DATA_WIDTH-1:0] req1_data_i,
  input  logic                  req1_swap_i,
  output logic                  req1_ready_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_id_o,
  input  logic                  m_ready_i
);

  localparam int NB = DATA_WIDTH / 8;

  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_id_q, m_id_d;
  logic                  last_grant_q, last_grant_d;

  logic                  can_load;
  logic                  pick1;
  logic                  xfer;
  logic                  sel_swap;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [DATA_WIDTH-1:0] swapped;
  logic [DATA_WIDTH-1:0] proc_data;

  // Requester 1 wins when it is the only one asking, or when both ask and 0 went last.
  always_comb begin
    can_load     = !m_valid_q || m_ready_i;
    pick1        = req1_valid_i && (!req0_valid_i || (last_grant_q == 1'b0));
    req0_ready_o = rst_n_i && can_load && req0_valid_i && !pick1;
    req1_ready_o = rst_n_i && can_load && pick1;
    xfer         = req0_ready_o || req1_ready_o;
  end

  always_comb begin
    sel_data = pick1 ? req1_data_i : req0_data_i;
    sel_swap = pick1 ? req1_swap_i : req0_swap_i;
    swapped  = '0;
    for (int k = 0; k < NB; k++) begin
      swapped[8*(NB-1-k) +: 8] = sel_data[8*k +: 8];
    end
    proc_data = sel_swap ? swapped : sel_data;
  end

  // Data and id only move on a transfer so a drained stage keeps its last word.
  always_comb begin
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_id_d       = m_id_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      m_valid_d    = 1'b1;
      m_data_d     = proc_data;
      m_id_d       = pick1;
      last_grant_d = pick1;
    end else if (m_ready_i) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_id_q       <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_id_q       <= m_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_id_o    = m_id_q;

endmodule

// File: tb/tb_byte_swap_arbiter.sv
// Self-checking bench for byte_swap_arbiter: a per-cycle reference model,
// directed literal checks and a 1000-word ordered stream scoreboard.
module tb_byte_swap_arbiter;

  localparam logic [31:0] BASE = 32'hAABB1122;
  localparam logic [31:0] D0   = 32'h01020304;
  localparam logic [31:0] D1   = 32'hA0B0C0D0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0_valid = 1'b0, req0_swap = 1'b0, req1_valid = 1'b0, req1_swap = 1'b0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        m_ready = 1'b0;
  logic        req0_ready, req1_ready, m_valid, m_id;
  logic [31:0] m_data;

  int checks = 0;
  int failures = 0;
  int rcv = 0;
  int sent = 0;
  int cyc = 0;
  logic stream_on = 1'b0;
  logic took;

  byte_swap_arbiter #(.DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_valid_i(req0_valid), .req0_data_i(req0_data), .req0_swap_i(req0_swap), .req0_ready_o(req0_ready),
    .req1_valid_i(req1_valid), .req1_data_i(req1_data), .req1_swap_i(req1_swap), .req1_ready_o(req1_ready),
    .m_valid_o(m_valid), .m_data_o(m_data), .m_id_o(m_id), .m_ready_i(m_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {<<8{w}};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the output slot is either empty or holds one word; the
  // requester that did not win last time has priority when both ask.
  logic        exp_valid = 1'b0, exp_id = 1'b0, exp_last = 1'b1;
  logic [31:0] exp_data = '0;
  logic        room, want1, exp_r0, exp_r1;

  always_comb begin
    room   = (exp_valid == 1'b0) || m_ready;
    want1  = req1_valid && (req0_valid ? (exp_last == 1'b0) : 1'b1);
    exp_r0 = rst_n && room && req0_valid && !want1;
    exp_r1 = rst_n && room && want1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_valid <= 1'b0; exp_data <= '0; exp_id <= 1'b0; exp_last <= 1'b1;
    end else if (exp_r0) begin
      exp_valid <= 1'b1; exp_data <= req0_swap ? bswap(req0_data) : req0_data;
      exp_id <= 1'b0; exp_last <= 1'b0;
    end else if (exp_r1) begin
      exp_valid <= 1'b1; exp_data <= req1_swap ? bswap(req1_data) : req1_data;
      exp_id <= 1'b1; exp_last <= 1'b1;
    end else if (m_ready) begin
      exp_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("model_ready0", {31'd0, req0_ready}, {31'd0, exp_r0});
    chk("model_ready1", {31'd0, req1_ready}, {31'd0, exp_r1});
    chk("model_valid", {31'd0, m_valid}, {31'd0, exp_valid});
    chk("model_data", m_data, exp_data);
    chk("model_id", {31'd0, m_id}, {31'd0, exp_id});
  end

  // Stream scoreboard: k-th consumed word must be the reversal of BASE+k.
  always @(posedge clk) begin
    if (stream_on && m_valid && m_ready) begin
      chk("stream_data", m_data, bswap(BASE + 32'(rcv)));
      rcv <= rcv + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [31:0] d, input logic id);
    chk({nm, "_valid"}, {31'd0, m_valid}, {31'd0, v});
    chk({nm, "_data"}, m_data, d);
    chk({nm, "_id"}, {31'd0, m_id}, {31'd0, id});
  endtask

  task automatic chk_rdy(input string nm, input logic r0, input logic r1);
    chk({nm, "_ready0"}, {31'd0, req0_ready}, {31'd0, r0});
    chk({nm, "_ready1"}, {31'd0, req1_ready}, {31'd0, r1});
  endtask

  initial begin
    logic [1:0] idseq [6];
    idseq = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};

    #2 rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; m_ready = 1'b1;
    #1;
    chk_out("por", 1'b0, 32'h0, 1'b0);
    chk_rdy("por", 1'b0, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single swap from requester 0
    step();
    req0_valid = 1'b1; req0_data = 32'hAABB1122; req0_swap = 1'b1; m_ready = 1'b1;
    #1;
    chk_rdy("swap", 1'b1, 1'b0);
    step();
    chk_out("swap", 1'b1, 32'h2211BBAA, 1'b0);
    req0_valid = 1'b0; req0_swap = 1'b0;
    step();
    chk_out("swap_drain", 1'b0, 32'h2211BBAA, 1'b0);

    // Bypass from requester 1
    req1_valid = 1'b1; req1_data = 32'h12345678; req1_swap = 1'b0;
    step();
    req1_valid = 1'b0; req1_swap = 1'b1;
    chk_out("bypass", 1'b1, 32'h12345678, 1'b1);
    step();

    // Contention from a fresh reset
    rst_n = 1'b0; #1; rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = D0; req0_swap = 1'b1;
    req1_valid = 1'b1; req1_data = D1; req1_swap = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_out("contend", 1'b1, (idseq[i] == 2'd0) ? 32'h04030201 : D1, idseq[i][0]);
    end

    // Backpressure: hold requester 1's word for five cycles
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("stall", 1'b1, D1, 1'b1);
      chk_rdy("stall", 1'b0, 1'b0);
    end
    m_ready = 1'b1;
    #1;
    chk_rdy("release", 1'b1, 1'b0);
    step();
    chk_out("release", 1'b1, 32'h04030201, 1'b0);

    // Reset asserted mid-stall, then first contention after release
    m_ready = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk_out("rst_mid", 1'b0, 32'h0, 1'b0);
    chk_rdy("rst_mid", 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    m_ready = 1'b1;
    step();
    chk_out("post_rst", 1'b1, 32'h04030201, 1'b0);
    step();
    chk_out("post_rst2", 1'b1, D1, 1'b1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // 1000-word stream with random downstream stalls
    rst_n = 1'b0; #1; rst_n = 1'b1;
    stream_on = 1'b1;
    while (sent < 1000 && cyc < 20000) begin
      req0_valid = 1'b1; req0_data = BASE + 32'(sent); req0_swap = 1'b1;
      m_ready = 1'($urandom_range(0, 1));
      #1 took = req0_ready;
      step();
      if (took) sent++;
      cyc++;
    end
    req0_valid = 1'b0; m_ready = 1'b1;
    repeat (5) step();
    chk("stream_sent", 32'(sent), 32'd1000);
    chk("stream_rcv", 32'(rcv), 32'd1000);
    stream_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_swap_arbiter.md
BYTE_SWAP_ARBITER -- requirements
Module: byte_swap_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, data word width in bits; SHALL be a non-zero multiple of 8.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid_i  input  1  requester 0 has a word.
REQ-005 req0_data_i  input  DATA_WIDTH  requester 0 word.
REQ-006 req0_swap_i  input  1  requester 0 mode: 1 = reverse byte order, 0 = pass through.
REQ-007 req0_ready_o  output  1  requester 0 word accepted this cycle.
REQ-008 req1_valid_i, req1_data_i, req1_swap_i, req1_ready_o: same widths and meanings for requester 1.
REQ-009 m_valid_o  output  1  output word valid.
REQ-010 m_data_o  output  DATA_WIDTH  processed word.
REQ-011 m_id_o  output  1  index of requester that sourced m_data_o.
REQ-012 m_ready_i  input  1  downstream accepts the output word.

Function
REQ-013 The block SHALL share one byte-order-swap datapath between two requesters via round-robin arbitration and a single registered output stage.
REQ-014 Byte reversal SHALL map input byte k (bits 8k+7:8k) to output byte N-1-k, N = DATA_WIDTH/8; pass-through SHALL copy the word unchanged.
REQ-015 Output stage "can_load" SHALL be true when m_valid_o = 0 or m_ready_i = 1.
REQ-016 Grant: only one requester valid -> that requester; both valid -> the requester not granted most recently (last_grant pointer); neither -> no grant.
REQ-017 reqN_ready_o SHALL be 1 only when can_load = 1, reqN_valid_i = 1 and requester N holds the grant; at most one ready_o is 1 in any cycle; ready_o is combinational from inputs and state.
REQ-018 On a transfer (valid and ready both 1), the next rising edge SHALL load m_data_o with the processed word, m_id_o with N, set m_valid_o = 1, and set last_grant = N.
REQ-019 Latency SHALL be exactly 1 cycle from requester transfer to m_valid_o; sustained throughput SHALL be 1 word/cycle while m_ready_i = 1.
REQ-020 If m_valid_o = 1 and m_ready_i = 0, m_data_o, m_id_o, m_valid_o SHALL hold stable and both ready_o SHALL be 0.
REQ-021 If m_ready_i = 1 and no requester transfers, m_valid_o SHALL clear to 0 at the next edge; m_data_o and m_id_o keep their last value.
REQ-022 Output consumed and new word loaded in the same cycle SHALL produce back-to-back valid words with no bubble.
REQ-023 last_grant SHALL update only on a transfer; an idle or stalled cycle SHALL NOT change arbitration order.
REQ-024 reqN_swap_i SHALL be sampled with the word in the transfer cycle; its later changes SHALL NOT affect a word already held in the output stage.
REQ-025 The block SHALL NOT drop or duplicate words: each requester transfer yields exactly one output transfer, in grant order.

Reset
REQ-026 rst_n_i = 0 SHALL immediately, without a clock edge, force m_valid_o = 0, m_data_o = 0, m_id_o = 0, last_grant = 1 (requester 0 wins the first contention).
REQ-027 While rst_n_i = 0, req0_ready_o and req1_ready_o SHALL be 0.
REQ-028 Reset asserted mid-stall SHALL discard the held word; first edge after deassertion SHALL behave as after power-up.

Verification
REQ-029 Single swap: req0 valid, data 32'hAABB1122, swap=1, m_ready_i=1 -> req0_ready_o=1 same cycle; next cycle m_valid_o=1, m_data_o=32'h2211BBAA, m_id_o=0.
REQ-030 Bypass: req1 data 32'h12345678, swap=0 -> next cycle m_data_o=32'h12345678, m_id_o=1.
REQ-031 Contention: both valid continuously from reset for 6 cycles, m_ready_i=1 -> m_id_o sequence 0,1,0,1,0,1, one word per cycle, no bubbles.
REQ-032 Backpressure: m_valid_o=1, m_ready_i=0 for 5 cycles with both requesters valid -> outputs unchanged, both ready_o=0; on m_ready_i=1, next grant goes to the requester not last granted.
REQ-033 Counter stream: req0 incrementing from 32'hAABB1122 for 1000 words, swap=1, random m_ready_i -> each output equals the byte-reversed input, in order, none lost or duplicated.
REQ-034 Reset mid-operation: assert rst_n_i between edges while m_valid_o=1 -> m_valid_o=0 and m_data_o=0 immediately; after release, req0 wins first contention.
